// File: rtl/gs_pipe_ctrl.sv
// Hazard controller for the GoldenSnitch 5-stage core: load-use bubbles, redirect
// flushes and LSU wait stalls, plus a saturating stall counter and sticky timeout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | no sequence in progress; new hazards detected here
// LU_STALL | inserting the remaining load-use bubbles
// FLUSH    | squashing wrong-path fetches after a redirect
// MEM_WAIT | holding IF/ID/EX until the LSU completes the access
module gs_pipe_ctrl #(
    parameter int LU_BUBBLES   = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 256,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic             ex_valid_i,
    input  logic             ex_MemRead_i,
    input  logic             ex_RegWrite_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic [1:0]       ex_PCSrc_i,
    input  logic             ex_br_taken_i,
    input  logic             lsu_req_i,
    input  logic             lsu_ready_i,
    input  logic             cnt_clr_i,
    output logic             halt_if_o,
    output logic             halt_id_o,
    output logic             halt_ex_o,
    output logic             flush_id_o,
    output logic             flush_ex_o,
    output logic             pc_redirect_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             mem_timeout_o
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [2:0]       rem_q, rem_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q;
    logic             mw, rd, lu;
    logic             h_if, h_id, h_ex, f_id, f_ex, redir;

    assign mw = ex_valid_i & lsu_req_i & ~lsu_ready_i;
    assign rd = ex_valid_i & ((ex_PCSrc_i == 2'b10) | ((ex_PCSrc_i == 2'b01) & ex_br_taken_i));
    assign lu = ex_valid_i & ex_MemRead_i & ex_RegWrite_i & (ex_rd_addr_i != 5'd0) & id_valid_i &
                ((id_uses_rs1_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                 (id_uses_rs2_i & (id_rs2_addr_i == ex_rd_addr_i)));

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        h_if = 1'b0; h_id = 1'b0; h_ex = 1'b0;
        f_id = 1'b0; f_ex = 1'b0; redir = 1'b0;
        case (state_q)
            RUN: begin
                if (mw) begin
                    h_if = 1'b1; h_id = 1'b1; h_ex = 1'b1;
                    state_d = MEM_WAIT;
                    wait_d  = WW'(1);
                end else if (rd) begin
                    redir = 1'b1; f_id = 1'b1; f_ex = 1'b1;
                    if (FLUSH_CYCLES != 0) begin
                        state_d = FLUSH;
                        rem_d   = 3'(FLUSH_CYCLES);
                    end
                end else if (lu) begin
                    h_if = 1'b1; h_id = 1'b1; f_ex = 1'b1;
                    if (LU_BUBBLES > 1) begin
                        state_d = LU_STALL;
                        rem_d   = 3'(LU_BUBBLES - 1);
                    end
                end
            end
            LU_STALL: begin
                h_if = 1'b1; h_id = 1'b1; f_ex = 1'b1;
                if (rem_q <= 3'd1) state_d = RUN;
                else               rem_d   = rem_q - 3'd1;
            end
            FLUSH: begin
                f_id = 1'b1; f_ex = 1'b1;
                if (rem_q <= 3'd1) state_d = RUN;
                else               rem_d   = rem_q - 3'd1;
            end
            MEM_WAIT: begin
                if (lsu_ready_i) begin
                    state_d = RUN;
                end else begin
                    h_if = 1'b1; h_id = 1'b1; h_ex = 1'b1;
                    if (wait_q < WW'(MEM_TIMEOUT)) wait_d = wait_q + WW'(1);
                    // this cycle is stall number wait_q+1 counting the RUN detect cycle
                    if (wait_q >= WW'(MEM_TIMEOUT - 1)) timeout_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            rem_q     <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            if (cnt_clr_i)                       cnt_q <= '0;
            else if (h_if && (cnt_q != '1))      cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign halt_if_o     = ~rst & h_if;
    assign halt_id_o     = ~rst & h_id;
    assign halt_ex_o     = ~rst & h_ex;
    assign flush_id_o    = ~rst & f_id;
    assign flush_ex_o    = ~rst & f_ex;
    assign pc_redirect_o = ~rst & redir;
    assign state_o       = rst ? 2'd0 : state_q;
    assign stall_cnt_o   = rst ? '0 : cnt_q;
    assign mem_timeout_o = ~rst & timeout_q;
endmodule

// File: tb/tb_gs_pipe_ctrl.sv
// Bench for gs_pipe_ctrl: directed hazard scenarios followed by random traffic,
// every cycle compared against a bubble/flush/wait bookkeeping model.
module tb_gs_pipe_ctrl;
    localparam int LB = 2, FC = 1, MT = 4, CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic id_valid, id_uses_rs1, id_uses_rs2, ex_valid, ex_memread, ex_regwrite;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic [1:0] ex_pcsrc;
    logic ex_taken, lsu_req, lsu_ready, cnt_clr;
    logic halt_if, halt_id, halt_ex, flush_id, flush_ex, pc_redirect, mem_timeout;
    logic [1:0] state;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // model: outstanding bubbles, outstanding flush cycles, pending memory wait
    int lu_left = 0, fl_left = 0, waited = 0, stall_total = 0;
    bit in_wait = 0, tmo = 0;

    always #5 clk = ~clk;

    gs_pipe_ctrl #(.LU_BUBBLES(LB), .FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid), .id_rs1_addr_i(id_rs1), .id_rs2_addr_i(id_rs2),
        .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
        .ex_valid_i(ex_valid), .ex_MemRead_i(ex_memread), .ex_RegWrite_i(ex_regwrite),
        .ex_rd_addr_i(ex_rd), .ex_PCSrc_i(ex_pcsrc), .ex_br_taken_i(ex_taken),
        .lsu_req_i(lsu_req), .lsu_ready_i(lsu_ready), .cnt_clr_i(cnt_clr),
        .halt_if_o(halt_if), .halt_id_o(halt_id), .halt_ex_o(halt_ex),
        .flush_id_o(flush_id), .flush_ex_o(flush_ex), .pc_redirect_o(pc_redirect),
        .state_o(state), .stall_cnt_o(stall_cnt), .mem_timeout_o(mem_timeout)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit ev_redirect();
        return ex_valid && (ex_pcsrc == 2'b10 || (ex_pcsrc == 2'b01 && ex_taken));
    endfunction

    function automatic bit ev_loaduse();
        bit reads = (id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd);
        return ex_valid && ex_memread && ex_regwrite && ex_rd != 0 && id_valid && reads;
    endfunction

    task automatic idle();
        id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
        ex_valid = 0; ex_memread = 0; ex_regwrite = 0; ex_rd = 0;
        ex_pcsrc = 0; ex_taken = 0; lsu_req = 0; lsu_ready = 0; cnt_clr = 0;
    endtask

    // EX: lw x5 ; ID: add x6,x5,x1
    task automatic set_loaduse(logic [4:0] rd);
        ex_valid = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = rd;
        id_valid = 1; id_uses_rs1 = 1; id_rs1 = 5; id_uses_rs2 = 1; id_rs2 = 1;
    endtask

    task automatic cycle();
        bit mw, rdr, lu, busy;
        bit e_hif, e_hid, e_hex, e_fid, e_fex, e_pc;
        int e_st;
        @(negedge clk);
        mw   = ex_valid && lsu_req && !lsu_ready;
        rdr  = ev_redirect();
        lu   = ev_loaduse();
        busy = (lu_left > 0) || (fl_left > 0) || in_wait;
        {e_hif, e_hid, e_hex, e_fid, e_fex, e_pc} = '0;
        e_st = lu_left > 0 ? 1 : fl_left > 0 ? 2 : in_wait ? 3 : 0;
        if (rst) e_st = 0;
        else if (lu_left > 0) {e_hif, e_hid, e_fex} = 3'b111;
        else if (fl_left > 0) {e_fid, e_fex} = 2'b11;
        else if (in_wait) begin
            if (!lsu_ready) {e_hif, e_hid, e_hex} = 3'b111;
        end else if (mw) {e_hif, e_hid, e_hex} = 3'b111;
        else if (rdr) {e_pc, e_fid, e_fex} = 3'b111;
        else if (lu) {e_hif, e_hid, e_fex} = 3'b111;
        checks++;
        assert (rst || busy || !(ex_valid && lsu_req && rdr)) else begin
            errors++;
            $error("FAIL illegal_req_with_redirect observed 1 expected 0");
        end
        chk("halt_if", halt_if, e_hif);
        chk("halt_id", halt_id, e_hid);
        chk("halt_ex", halt_ex, e_hex);
        chk("flush_id", flush_id, e_fid);
        chk("flush_ex", flush_ex, e_fex);
        chk("pc_redirect", pc_redirect, e_pc);
        chk("state", state, e_st);
        chk("stall_cnt", stall_cnt, rst ? 0 : stall_total);
        chk("mem_timeout", mem_timeout, rst ? 0 : tmo);
        @(posedge clk);
        if (rst) begin
            lu_left = 0; fl_left = 0; in_wait = 0; waited = 0; tmo = 0; stall_total = 0;
        end else begin
            if (lu_left > 0) lu_left--;
            else if (fl_left > 0) fl_left--;
            else if (in_wait) begin
                if (lsu_ready) in_wait = 0;
                else begin
                    waited++;
                    if (waited >= MT) tmo = 1;
                end
            end else if (mw) begin
                in_wait = 1; waited = 1;
            end else if (rdr) fl_left = FC;
            else if (lu) lu_left = LB - 1;
            if (cnt_clr) stall_total = 0;
            else if (e_hif) stall_total = (stall_total + 1 > 2**CW - 1) ? 2**CW - 1 : stall_total + 1;
        end
        #1;
    endtask

    initial begin
        idle();
        rst = 1;
        cycle(); cycle();
        rst = 0;
        cycle();
        chk("reset_state", state, 0);
        chk("reset_cnt", stall_cnt, 0);

        // load-use with LB = 2 bubbles
        set_loaduse(5); cycle(); cycle();
        idle(); cycle();
        chk("lu_stall_cnt", stall_cnt, 2);
        set_loaduse(0); #1;
        chk("lu_x0_no_halt", halt_if, 0);
        cycle(); idle(); cycle();

        // taken / not-taken branch
        ex_valid = 1; ex_pcsrc = 2'b01; ex_taken = 1; #1;
        chk("br_redirect", pc_redirect, 1);
        cycle(); idle(); #1;
        chk("br_flush_tail", flush_id, 1);
        chk("br_flush_no_redirect", pc_redirect, 0);
        cycle(); cycle();
        ex_valid = 1; ex_pcsrc = 2'b01; ex_taken = 0; #1;
        chk("br_not_taken", flush_ex, 0);
        cycle(); idle();

        // memory wait, ready on the 6th cycle
        cnt_clr = 1; cycle(); cnt_clr = 0;
        ex_valid = 1; lsu_req = 1;
        repeat (5) cycle();
        lsu_ready = 1; #1;
        chk("mw_release", halt_if, 0);
        cycle(); idle(); cycle();
        chk("mw_stall_cnt", stall_cnt, 5);
        chk("mw_timeout", mem_timeout, 1);

        // reset in the middle of a memory wait
        ex_valid = 1; lsu_req = 1; cycle(); cycle();
        rst = 1; cycle();
        rst = 0; idle(); #1;
        chk("rst_mid_state", state, 0);
        chk("rst_mid_cnt", stall_cnt, 0);
        chk("rst_mid_tmo", mem_timeout, 0);
        chk("rst_mid_halt", halt_ex, 0);
        cycle();

        // load-use together with a jump: redirect wins
        set_loaduse(5); ex_pcsrc = 2'b10; #1;
        chk("lu_rd_halt", halt_if, 0);
        chk("lu_rd_redirect", pc_redirect, 1);
        cycle(); idle(); cycle(); cycle();

        // memory wait together with load-use: bubble after release
        set_loaduse(5); lsu_req = 1; cycle(); cycle();
        lsu_ready = 1; cycle();
        lsu_req = 0; lsu_ready = 0; cycle();
        chk("mw_lu_bubble_state", state, 1);
        idle(); cycle(); cycle();

        // timeout and counter saturation
        cnt_clr = 1; cycle(); cnt_clr = 0;
        ex_valid = 1; lsu_req = 1;
        repeat (10) cycle();
        chk("sat_cnt", stall_cnt, 7);
        chk("tmo_set", mem_timeout, 1);
        lsu_ready = 1; cycle(); idle(); cycle();
        chk("tmo_sticky", mem_timeout, 1);
        cnt_clr = 1; cycle(); cnt_clr = 0;
        chk("cnt_clr", stall_cnt, 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            ex_valid    = $urandom_range(0, 3) != 0;
            ex_memread  = $urandom_range(0, 1) != 0;
            ex_regwrite = $urandom_range(0, 3) != 0;
            ex_rd       = 5'($urandom_range(0, 3));
            id_valid    = $urandom_range(0, 3) != 0;
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_uses_rs1 = $urandom_range(0, 1) != 0;
            id_uses_rs2 = $urandom_range(0, 1) != 0;
            ex_pcsrc    = 2'($urandom_range(0, 3));
            ex_taken    = $urandom_range(0, 1) != 0;
            lsu_ready   = $urandom_range(0, 2) == 0;
            lsu_req     = ($urandom_range(0, 3) == 0) && !ev_redirect();
            cnt_clr     = $urandom_range(0, 15) == 0;
            rst         = $urandom_range(0, 79) == 0;
            cycle();
        end
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
